core_hazard_ctrl: RTL
=====================

// Module: core_hazard_ctrl
// PURPOSE
//  Next-generation pipeline hazard/stall controller. Detects load-use hazards for NUM_SRC operands
//  over LOAD_LATENCY stages, and stalls on mem-bus wait. Owns a sequential peripheral-access FSM
//  that holds d_valid until d_ready, blocks re-issue while the pipe is frozen, and optionally times out.
//  Sits between decode/EX control and the data-peripheral/mem-bus ports; its stall freezes IF/ID/EX.
// PARAMETERS
//  XLEN            64            address width
//  NUM_SRC         3             source-operand ports checked for load-use (rs, rt, rd-as-src)
//  LOAD_LATENCY    1             1: check ID stage only; 2: also check EX stage load
//  PERIPHERAL_BASE 64'h2000_0000 inclusive lower bound of peripheral window
//  PERIPHERAL_TOP  64'hFFFF_FFFF inclusive upper bound of peripheral window
//  TIMEOUT_CYCLES  255           peripheral wait limit (used only with HAZARD_TIMEOUT_EN)
// PORTS
//  clock         in  1             core clock
//  reset         in  1             asynchronous, active-high
//  IF_src        in  NUM_SRC*5     packed source regnums, src i at [5i+4:5i]
//  IF_src_used   in  NUM_SRC       bit i: src i is actually read
//  ID_W_regnum   in  5             ID-stage destination
//  ID_mem_read   in  1             ID-stage instruction is a load
//  EX_W_regnum   in  5             EX-stage destination (LOAD_LATENCY==2 only)
//  EX_mem_read   in  1             EX-stage load
//  EX_mem_write  in  1             EX-stage store
//  addr          in  XLEN          EX-stage effective address
//  d_ready       in  1             peripheral completes access this cycle
//  d_valid       out 1             peripheral access request
//  d_err         out 1             1-cycle pulse: peripheral timed out
//  mem_bus_req   in  1             mem-bus request outstanding
//  mem_bus_ready in  1             mem-bus done
//  stall         out 1             freeze IF/ID/EX
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE, wait counter=0, d_err=0; d_valid/stall follow comb rules with FSM=IDLE.
//  - load_use = OR over i of IF_src_used[i] && IF_src[i]!=0 && ((ID_mem_read && IF_src[i]==ID_W_regnum)
//      || (LOAD_LATENCY==2 && EX_mem_read && IF_src[i]==EX_W_regnum)). Combinational.
//  - periph_hit = (EX_mem_read|EX_mem_write) && BASE<=addr<=TOP (unsigned, full XLEN compare).
//  - bus_wait = mem_bus_req && !mem_bus_ready.
//  - FSM states: IDLE, ACCESS, HOLD.
//    IDLE:   d_valid=periph_hit. If periph_hit && !d_ready -> ACCESS. If periph_hit && d_ready -> HOLD
//            when (load_use|bus_wait), else stay IDLE (zero-wait access, no stall from peripheral).
//    ACCESS: d_valid=1, counter++. d_ready -> HOLD if (load_use|bus_wait) else IDLE.
//    HOLD:   d_valid=0 (no re-issue of completed access); -> IDLE when stall==0 (pipe advanced).
//  - periph_stall = d_valid && !d_ready. stall = load_use | periph_stall | bus_wait.
//  - d_ready while FSM=IDLE and !periph_hit is ignored. Counter clears on every exit from ACCESS.
//  - If EX op drops (periph_hit=0) while in ACCESS (not legal while stalled): -> IDLE, counter=0.
//  - Simultaneous d_ready and timeout: d_ready wins, no d_err.
// CONFIGURATION
//  HAZARD_TIMEOUT_EN defined: in ACCESS, when counter==TIMEOUT_CYCLES and !d_ready, pulse d_err=1
//    (registered, next cycle), drop d_valid, -> HOLD. Counter width $clog2(TIMEOUT_CYCLES+1).
//  Undefined: no counter, d_err tied 0, ACCESS waits indefinitely for d_ready.
// STRUCTURE
//  Package core_hazard_pkg: typedef enum logic [1:0] {HZ_IDLE, HZ_ACCESS, HZ_HOLD} hz_state_t;
//    function in_window(addr, base, top); REGNUM_W=5 constant.
//  Sub-module core_hazard_periph_fsm: FSM + timeout counter; inputs periph_hit, d_ready, other_stall;
//    outputs d_valid, periph_stall, d_err. Top holds load-use compare and stall OR.
// TESTING
//  1 ID_mem_read=1, ID_W_regnum=8, IF_src[1]=8, used=1 -> stall=1; used=0 -> stall=0; regnum 0 -> stall=0.
//  2 LOAD_LATENCY=2, EX_mem_read=1, EX_W_regnum=5, IF_src[0]=5 -> stall=1; LOAD_LATENCY=1 -> stall=0.
//  3 EX_mem_read, addr=0x2000_0010, d_ready low 3 cycles then high -> d_valid=1 for 4 cycles,
//    stall=1 for 3, 0 on the d_ready cycle; FSM back to IDLE.
//  4 Same, with bus_wait held 2 cycles past d_ready -> FSM HOLD, d_valid=0, stall=1 until mem_bus_ready.
//  5 HAZARD_TIMEOUT_EN, TIMEOUT_CYCLES=4, d_ready never -> d_err single pulse, d_valid drops, stall releases.
//  6 Assert reset mid-ACCESS -> d_valid follows periph_hit from IDLE immediately, counter 0, no d_err.

Source files
------------

// File: rtl/core_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
package core_hazard_pkg;

    localparam int unsigned REGNUM_W = 5;

    typedef enum logic [1:0] {
        HZ_IDLE,
        HZ_ACCESS,
        HZ_HOLD
    } hz_state_t;

    // Inclusive unsigned window test; callers zero-extend narrower addresses.
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] top);
        return (addr >= base) && (addr <= top);
    endfunction

endpackage

// File: rtl/core_hazard_periph_fsm.sv
// Peripheral-access sequencer: holds d_valid until d_ready and blocks re-issue while the pipe is frozen.
// Optional access timeout is enabled by defining HAZARD_TIMEOUT_EN.
module core_hazard_periph_fsm
    import core_hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic periph_hit,
    input  logic d_ready,
    input  logic other_stall,
    output logic d_valid,
    output logic periph_stall,
    output logic d_err
);

    hz_state_t state_q, state_d;
    logic      timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HZ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_valid = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                d_valid = periph_hit;
                // A zero-wait access only parks in HOLD if something else keeps the pipe frozen.
                if (periph_hit) begin
                    if (!d_ready) begin
                        state_d = HZ_ACCESS;
                    end else if (other_stall) begin
                        state_d = HZ_HOLD;
                    end
                end
            end
            HZ_ACCESS: begin
                d_valid = 1'b1;
                if (!periph_hit) begin
                    state_d = HZ_IDLE;
                end else if (d_ready) begin
                    state_d = other_stall ? HZ_HOLD : HZ_IDLE;
                end else if (timeout) begin
                    state_d = HZ_HOLD;
                end
            end
            HZ_HOLD: begin
                if (!other_stall) begin
                    state_d = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
            end
        endcase
    end

    assign periph_stall = d_valid && !d_ready;

`ifdef HAZARD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counter runs only while staying in ACCESS, so every exit clears it.
    always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (state_q == HZ_ACCESS && state_d == HZ_ACCESS) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == HZ_ACCESS && periph_hit && !d_ready && timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign d_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
    assign d_err              = 1'b0;
`endif

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use detection, mem-bus wait and peripheral access stalls.
// Define HAZARD_TIMEOUT_EN to enable the peripheral access timeout (d_err).
module core_hazard_ctrl
    import core_hazard_pkg::*;
#(
    parameter int unsigned     XLEN            = 64,
    parameter int unsigned     NUM_SRC         = 3,
    parameter int unsigned     LOAD_LATENCY    = 1,
    parameter logic [XLEN-1:0] PERIPHERAL_BASE = XLEN'(64'h2000_0000),
    parameter logic [XLEN-1:0] PERIPHERAL_TOP  = XLEN'(64'hFFFF_FFFF),
    parameter int unsigned     TIMEOUT_CYCLES  = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_SRC*REGNUM_W-1:0] IF_src,
    input  logic [NUM_SRC-1:0]          IF_src_used,
    input  logic [REGNUM_W-1:0]         ID_W_regnum,
    input  logic                        ID_mem_read,
    input  logic [REGNUM_W-1:0]         EX_W_regnum,
    input  logic                        EX_mem_read,
    input  logic                        EX_mem_write,
    input  logic [XLEN-1:0]             addr,
    input  logic                        d_ready,
    output logic                        d_valid,
    output logic                        d_err,
    input  logic                        mem_bus_req,
    input  logic                        mem_bus_ready,
    output logic                        stall
);

    localparam logic CHECK_EX = (LOAD_LATENCY == 2);

    logic load_use;
    logic periph_hit;
    logic bus_wait;
    logic periph_stall;

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        load_use = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (IF_src_used[i] && IF_src[i*REGNUM_W +: REGNUM_W] != '0) begin
                if (ID_mem_read && IF_src[i*REGNUM_W +: REGNUM_W] == ID_W_regnum) begin
                    load_use = 1'b1;
                end
                if (CHECK_EX && EX_mem_read && IF_src[i*REGNUM_W +: REGNUM_W] == EX_W_regnum) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    assign periph_hit = (EX_mem_read || EX_mem_write)
                        && in_window(64'(addr), 64'(PERIPHERAL_BASE), 64'(PERIPHERAL_TOP));
    assign bus_wait   = mem_bus_req && !mem_bus_ready;

    core_hazard_periph_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_periph_fsm (
        .clock        (clock),
        .reset        (reset),
        .periph_hit   (periph_hit),
        .d_ready      (d_ready),
        .other_stall  (load_use || bus_wait),
        .d_valid      (d_valid),
        .periph_stall (periph_stall),
        .d_err        (d_err)
    );

    assign stall = load_use || periph_stall || bus_wait;

endmodule
